cache_req_arbiter: RTL

- Shares one port of the 2-way set-associative cache between two requesters (r0, r1), such as an instruction fetch unit and a load/store unit.
- Arbitrates round-robin and keeps at most one transaction outstanding.
- Sequences each cache access with a one-cycle request pulse, waits for completion or timeout, then returns read data and the hit flag to the owning requester.
- Keeps saturating hit/miss statistics and a sticky timeout error flag.

---
 rtl/cache_req_arbiter_if.sv | 50 +++++
 rtl/cache_req_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter_if.sv
// Requester and cache bundle for cache_req_arbiter.
// master: arbiter side; slave: requesters plus cache side.
interface cache_req_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              r0_valid;
    logic              r0_ready;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_rsp_valid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_hit;

    logic              r1_valid;
    logic              r1_ready;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_rsp_valid;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_hit;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_done;
    logic [DATA_W-1:0] c_rdata;
    logic              c_hit;

    modport master (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rsp_valid, r0_rdata, r0_hit,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rsp_valid, r1_rdata, r1_hit,
        output c_req, c_we, c_addr, c_wdata,
        input  c_done, c_rdata, c_hit
    );

    modport slave (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rsp_valid, r0_rdata, r0_hit,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rsp_valid, r1_rdata, r1_hit,
        input  c_req, c_we, c_addr, c_wdata,
        output c_done, c_rdata, c_hit
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache port between r0 and r1.
// Ports: clk, reset, bus (requesters + cache), busy, hit/miss counts, timeout_err.
module cache_req_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    cache_req_arbiter_if.master bus,
    output logic                busy,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Timer counts 0..TIMEOUT-1; the last WAIT cycle is when it holds TIMEOUT-1.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              own_q, own_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_q, req_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              rsp_q, rsp_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              ht0_q, ht0_d, ht1_q, ht1_d;
    logic              hcap_q, hcap_d;
    logic              to_q, to_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d, mcnt_q, mcnt_d;
    logic              terr_q, terr_d;

    logic pick1, rdy0, rdy1;

    // On a tie rr_q selects the winner (0 = r0).
    assign pick1 = bus.r1_valid & (~bus.r0_valid | rr_q);
    assign rdy0  = ~reset & (state_q == IDLE) & bus.r0_valid & ~pick1;
    assign rdy1  = ~reset & (state_q == IDLE) & pick1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = 1'b0;
        tmr_d   = tmr_q;
        rsp_d   = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        ht0_d   = ht0_q;
        ht1_d   = ht1_q;
        hcap_d  = hcap_q;
        to_d    = to_q;
        hcnt_d  = hcnt_q;
        mcnt_d  = mcnt_q;
        terr_d  = terr_q;
        unique case (state_q)
            IDLE: begin
                if (rdy0 | rdy1) begin
                    own_d   = rdy1;
                    we_d    = rdy1 ? bus.r1_we    : bus.r0_we;
                    addr_d  = rdy1 ? bus.r1_addr  : bus.r0_addr;
                    wdata_d = rdy1 ? bus.r1_wdata : bus.r0_wdata;
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmr_d   = '0;
                to_d    = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.c_done) begin
                    hcap_d = bus.c_hit;
                    rsp_d  = 1'b1;
                    if (own_q) begin
                        rd1_d = bus.c_rdata;
                        ht1_d = bus.c_hit;
                    end else begin
                        rd0_d = bus.c_rdata;
                        ht0_d = bus.c_hit;
                    end
                    state_d = RESP;
                end else if (tmr_q == T_LAST) begin
                    hcap_d = 1'b0;
                    to_d   = 1'b1;
                    terr_d = 1'b1;
                    rsp_d  = 1'b1;
                    if (own_q) begin
                        rd1_d = '0;
                        ht1_d = 1'b0;
                    end else begin
                        rd0_d = '0;
                        ht0_d = 1'b0;
                    end
                    state_d = RESP;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            RESP: begin
                rr_d = ~own_q;
                if (!to_q) begin
                    if (hcap_q) begin
                        if (hcnt_q != '1) hcnt_d = hcnt_q + CNT_W'(1);
                    end else begin
                        if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            tmr_q   <= '0;
            rsp_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            ht0_q   <= 1'b0;
            ht1_q   <= 1'b0;
            hcap_q  <= 1'b0;
            to_q    <= 1'b0;
            hcnt_q  <= '0;
            mcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            tmr_q   <= tmr_d;
            rsp_q   <= rsp_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            ht0_q   <= ht0_d;
            ht1_q   <= ht1_d;
            hcap_q  <= hcap_d;
            to_q    <= to_d;
            hcnt_q  <= hcnt_d;
            mcnt_q  <= mcnt_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.r0_ready     = rdy0;
    assign bus.r1_ready     = rdy1;
    assign bus.r0_rsp_valid = rsp_q & ~own_q;
    assign bus.r1_rsp_valid = rsp_q & own_q;
    assign bus.r0_rdata     = rd0_q;
    assign bus.r1_rdata     = rd1_q;
    assign bus.r0_hit       = ht0_q;
    assign bus.r1_hit       = ht1_q;
    assign bus.c_req        = req_q;
    assign bus.c_we         = we_q;
    assign bus.c_addr       = addr_q;
    assign bus.c_wdata      = wdata_q;

    assign busy        = (state_q != IDLE);
    assign hit_count   = hcnt_q;
    assign miss_count  = mcnt_q;
    assign timeout_err = terr_q;
endmodule
